// File: rtl/irq_controller.sv
// irq_controller: edge-latched, masked, fixed-priority interrupt controller with ack/done handshake
module irq_controller #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               interupt,
  input  logic               intr_ack,
  input  logic               intr_done,
  output logic [ID_W-1:0]    intr_id,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
  state_t state, state_d;
  logic [NUM_SRC-1:0] src_q, pending, enable, eligible, claim, set_m, clr_m, wmask;
  logic [ID_W-1:0] winner;
  logic [31:0] status;
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;
  assign wmask    = cfg_wdata[NUM_SRC-1:0];
  assign eligible = pending & enable;
  assign set_m    = (irq_src & ~src_q) | ((cfg_we && cfg_addr == 2'd3) ? wmask : '0);
  assign clr_m    = (cfg_we && cfg_addr == 2'd1) ? wmask : '0;
  // claim is taken from eligible as it stood before any same-cycle write
  assign claim    = (state == REQ && intr_ack) ? ((NUM_SRC'(1) << winner) & eligible) : '0;
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (eligible[i]) winner = ID_W'(i);
  end
  always_comb begin
    state_d = state;
    if (state == IDLE && eligible != '0) state_d = REQ;
    else if (state == REQ) state_d = intr_ack ? SERVICE : (eligible == '0 ? IDLE : REQ);
    else if (state == SERVICE && intr_done) state_d = IDLE;
  end
  always_comb begin
    status = {28'b0, state, 2'b0};
    status[ID_W-1:0] = intr_id;
    cfg_rdata = cfg_addr == 2'd0 ? 32'(enable) :
                cfg_addr == 2'd1 ? 32'(pending) :
                cfg_addr == 2'd2 ? status : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      interupt <= 1'b0;
      intr_id  <= '0;
      enable   <= '0;
      pending  <= '0;
      src_q    <= '0;
    end else begin
      src_q    <= irq_src;
      pending  <= (pending & ~clr_m & ~claim) | set_m;
      state    <= state_d;
      interupt <= state_d == REQ;
      if (cfg_we && cfg_addr == 2'd0) enable <= wmask;
      if (state == REQ && intr_ack) intr_id <= winner;
    end
  end
endmodule

// File: doc/irq_controller.md
# irq_controller

Platform interrupt controller that drives the core's `interupt` input. It latches rising edges on up to NUM_SRC external sources into a pending register, masks them with an enable register, and raises `interupt` to the core. It then runs a request / acknowledge / complete handshake so that exactly one source is serviced at a time. It sits outside `Processor`, beside the data memory. Configuration goes through a simple single-cycle register port.

## Interface
- NUM_SRC, 4: number of interrupt sources (2..32).
- ID_W, $clog2(NUM_SRC): width of the source id.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-low; clears all state.
- irq_src  in  NUM_SRC  source lines, synchronous to clk; a rising edge is an event.
- interupt  out  1  interrupt request to the core; registered.
- intr_ack  in  1  core accepted the trap (trap entry); meaningful only in REQ.
- intr_done  in  1  core finished the handler (mret); meaningful only in SERVICE.
- intr_id  out  ID_W  id of the source being serviced; registered.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  2  register select.
- cfg_wdata  in  32  write data; bits at and above NUM_SRC are ignored.
- cfg_rdata  out  32  combinational read data, zero-extended.

## Operation
- Registers, selected by cfg_addr:
  - 0 ENABLE: read/write mask.
  - 1 PENDING: read; write 1 to clear.
  - 2 STATUS: read-only {28'b0, state[1:0], 2'b0} with intr_id in bits [ID_W-1:0] overlaid; writes to it are ignored.
  - 3 SWTRIG: write 1 to set pending; reads as 0.
- Edge detect: src_q <= irq_src every cycle. An event is irq_src[i] & ~src_q[i].
- Pending update per bit, in priority order:
  - an event or an SWTRIG set sets the bit, and this wins over any clear in the same cycle;
  - otherwise a PENDING W1C clears it;
  - otherwise a claim clears it.
- eligible = pending & enable. The winner is the lowest-index set bit of eligible.
- FSM states: IDLE=0, REQ=1, SERVICE=2.
  - IDLE: if eligible != 0, go to REQ.
  - REQ: if intr_ack, claim (intr_id <= winner, clear pending[winner]) and go to SERVICE. Else if eligible == 0 (withdrawn by mask or W1C), go to IDLE. Else stay in REQ.
  - SERVICE: if intr_done, go to IDLE. New events accumulate in pending and are not delivered until the controller is back in IDLE.
- interupt is high exactly when state == REQ.
- intr_ack outside REQ and intr_done outside SERVICE are ignored.
- The winner is evaluated in the ack cycle, not at REQ entry. A lower-index source arriving during REQ is therefore the one claimed.
- Priority is fixed, lowest index first. Starvation of high-index sources is permitted.

## Timing
- Reset values (asynchronous, while rst=0): state=IDLE, interupt=0, intr_id=0, enable=0, pending=0, src_q=0.
- A source already high when reset releases produces an event on the first clock edge.
- Latency:
  - event sampled at edge k: pending set after k;
  - IDLE→REQ at k+1, so interupt=1 after k+1;
  - ack sampled at edge m: interupt=0 and intr_id valid after m;
  - done sampled at edge n: IDLE after n; if another source is still eligible, interupt=1 again after n+1.
- A config write at edge k is visible in cfg_rdata and eligible after k. An ENABLE write at k can move IDLE to REQ at k+1.
- Simultaneous intr_ack and a W1C of the winner's bit in REQ: the ack is honoured using eligible from before the write, and the bit ends up clear.
- intr_done held high across several cycles: only the SERVICE→IDLE transition acts; the extra cycles are ignored.
- A reset asserted mid-handshake aborts it immediately; pending events are lost.

## Test plan
- Reset behaviour: drive irq_src=0 and release rst. ENABLE=4'hF. Pulse irq_src[2] at edge 5 → interupt=1 two cycles later. Ack → intr_id=2, PENDING reads 0, STATUS state=2. Done → state=0, interupt=0.
- Priority: ENABLE=4'hF, raise src[3] and src[1] in the same cycle. Ack → id=1, PENDING=4'b1000. Done → interupt re-asserts one cycle after returning to IDLE. Ack → id=3.
- Masking and withdrawal: ENABLE=0, event on src[0] → PENDING=1, interupt stays 0. ENABLE=1 → interupt=1 next cycle. In REQ, W1C PENDING=1 → IDLE, interupt=0, and the ack pulsed afterwards is ignored.
- Set-wins collision: W1C of bit 2 in the same cycle as an irq_src[2] rising edge → PENDING bit 2 stays 1. SWTRIG write 4'b0001 → pending[0]=1, interupt=1 two cycles later.
- Stray handshake signals: pulse intr_done in IDLE and intr_ack in SERVICE → no state change, intr_id unchanged. Events arriving during SERVICE stay pending until done.
- Mid-operation reset: assert rst low in SERVICE with PENDING=4'b0110 → asynchronously interupt=0, intr_id=0, ENABLE and PENDING read 0. Hold src[1] high through the release → event on the first edge, pending[1]=1.
